// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read and captures IR.
// Optional FETCH_ADDR_CHECK_EN: misaligned/out-of-range fetches fault without a memory access.
module fetch_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned     IMEM_DEPTH  = 32,
   parameter int unsigned     MEM_LATENCY = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_start,
   input  logic            pc_write,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [31:0]     mem_instr,
   output logic            mem_sel,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] old_pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic [31:0]     ir,
   output logic            ir_valid,
   output logic            busy,
   output logic            addr_err
);

   localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_ADDR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              pend_valid, pend_n;
   logic [XLEN-1:0]   pend_target, pend_tgt_n;
   logic [XLEN-1:0]   pc_n, old_pc_n, mem_addr_n, redir_tgt;
   logic [31:0]       ir_n;
   logic              ir_valid_n, addr_err_n, mem_sel_n, busy_n, redir_ok, fault;

   assign pc_plus4 = pc + XLEN'(4);

   // Redirect target selected by pc_src; 11 holds the current pc.
   always_comb begin
      redir_tgt = pc;
      case (pc_src)
         2'b00:   redir_tgt = pc_plus4;
         2'b01:   redir_tgt = branch_target;
         2'b10:   redir_tgt = jump_target;
         default: redir_tgt = pc;
      endcase
   end

   assign redir_ok = pc_write && (pc_src != 2'b11);

   // Next-state and next-output logic.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      pend_n     = pend_valid;
      pend_tgt_n = pend_target;
      pc_n       = pc;
      old_pc_n   = old_pc;
      mem_addr_n = mem_addr;
      ir_n       = ir;
      ir_valid_n = 1'b0;
      addr_err_n = 1'b0;
      fault      = 1'b0;

      case (state)
         IDLE: begin
            if (pc_write) pc_n = redir_tgt;
            if (fetch_start) begin
               mem_addr_n = pc_n;
               fault = CHECK_EN && ((pc_n[1:0] != 2'b00) ||
                                    ((pc_n >> 2) >= XLEN'(IMEM_DEPTH)));
               if (fault) begin
                  ir_n       = NOP;
                  old_pc_n   = pc_n;
                  ir_valid_n = 1'b1;
                  addr_err_n = 1'b1;
               end else begin
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            if (redir_ok) begin
               pend_n     = 1'b1;
               pend_tgt_n = redir_tgt;
            end
            cnt_n   = CNT_W'(MEM_LATENCY);
            state_n = WAIT;
         end
         WAIT: begin
            if (redir_ok) begin
               pend_n     = 1'b1;
               pend_tgt_n = redir_tgt;
            end
            if (cnt == CNT_W'(1)) begin
               ir_n       = mem_instr;
               old_pc_n   = mem_addr;
               ir_valid_n = 1'b1;
               pc_n       = pend_n ? pend_tgt_n : mem_addr + XLEN'(4);
               pend_n     = 1'b0;
               state_n    = IDLE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Read select is low only for the single request cycle.
      mem_sel_n = (state_n != REQ);
      busy_n    = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         pc          <= RESET_PC;
         old_pc      <= RESET_PC;
         mem_addr    <= RESET_PC;
         ir          <= NOP;
         ir_valid    <= 1'b0;
         addr_err    <= 1'b0;
         mem_sel     <= 1'b1;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         pend_valid  <= pend_n;
         pend_target <= pend_tgt_n;
         pc          <= pc_n;
         old_pc      <= old_pc_n;
         mem_addr    <= mem_addr_n;
         ir          <= ir_n;
         ir_valid    <= ir_valid_n;
         addr_err    <= addr_err_n;
         mem_sel     <= mem_sel_n;
         busy        <= busy_n;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural imem plus a queue of expected captures.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_start, pc_write;
   logic [1:0]  pc_src;
   logic [31:0] branch_target, jump_target, mem_instr;
   logic        mem_sel, ir_valid, busy, addr_err;
   logic [31:0] mem_addr, pc, old_pc, pc_plus4, ir;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] imem [32];
   logic [31:0] nxt;
   int          errors = 0;
   int          checks = 0;
   int          n, caps, last;

   fetch_unit dut (
      .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_write(pc_write),
      .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
      .mem_instr(mem_instr), .mem_sel(mem_sel), .mem_addr(mem_addr), .pc(pc),
      .old_pc(old_pc), .pc_plus4(pc_plus4), .ir(ir), .ir_valid(ir_valid),
      .busy(busy), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   // One-cycle-latency instruction memory.
   always @(posedge clk) if (mem_sel == 1'b0) mem_instr <= imem[mem_addr[6:2]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; fetch_start = 1'b0; pc_write = 1'b0; pc_src = 2'b00;
      branch_target = '0; jump_target = '0;
      exp_q.delete();
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pc !== 32'h0 || old_pc !== 32'h0 || mem_addr !== 32'h0) begin
         errors++; $display("FAIL reset_addrs pc=%0h old_pc=%0h mem_addr=%0h exp=0", pc, old_pc, mem_addr); end
      checks++; if (ir !== 32'h13) begin
         errors++; $display("FAIL reset_ir got=%0h exp=13", ir); end
      checks++; if ({mem_sel, busy, ir_valid, addr_err} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctl sel/busy/valid/err got=%b exp=1000", {mem_sel, busy, ir_valid, addr_err}); end
      checks++; if (pc_plus4 !== 32'h4) begin
         errors++; $display("FAIL reset_pc_plus4 got=%0h exp=4", pc_plus4); end
   endtask

   task automatic test_single();
      do_reset();
      fetch_start = 1'b1; exp_q.push_back('{32'h0050_0093, 32'h0});
      tick(); fetch_start = 1'b0;
      checks++; if (mem_sel !== 1'b0 || mem_addr !== 32'h0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_req sel=%b addr=%0h busy=%b exp 0/0/1", mem_sel, mem_addr, busy); end
      tick();
      checks++; if (mem_sel !== 1'b1 || ir_valid !== 1'b0) begin
         errors++; $display("FAIL single_wait sel=%b valid=%b exp 1/0", mem_sel, ir_valid); end
      tick();
      checks++; if (ir_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL single_valid got=%b exp=1", ir_valid);
      end else begin
         e = exp_q.pop_front();
         if (ir !== e.ir || old_pc !== e.pc || pc !== 32'h4) begin
            errors++; $display("FAIL single_capture ir=%0h old_pc=%0h pc=%0h exp %0h/%0h/4", ir, old_pc, pc, e.ir, e.pc); end
      end
      tick();
      checks++; if (ir_valid !== 1'b0 || ir !== 32'h0050_0093) begin
         errors++; $display("FAIL single_pulse valid=%b ir=%0h exp 0/500093", ir_valid, ir); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fetch_start = 1'b1; exp_q.push_back('{imem[0], 32'h0}); nxt = 32'h4;
      caps = 0; last = 0;
      for (int cyc = 1; cyc < 30 && caps < 3; cyc++) begin
         tick();
         if (mem_sel === 1'b0 && exp_q.size() != 0) begin
            checks++; if (mem_addr !== exp_q[0].pc) begin
               errors++; $display("FAIL b2b_addr got=%0h exp=%0h", mem_addr, exp_q[0].pc); end
         end
         if (ir_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra capture ir=%0h exp none", ir);
            end else begin
               e = exp_q.pop_front();
               if (ir !== e.ir || old_pc !== e.pc) begin
                  errors++; $display("FAIL b2b_capture ir=%0h old_pc=%0h exp %0h/%0h", ir, old_pc, e.ir, e.pc); end
            end
            if (caps > 0) begin
               checks++; if (cyc - last != 3) begin
                  errors++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last); end
            end
            last = cyc; caps++;
            if (caps < 3) begin
               exp_q.push_back('{imem[nxt[6:2]], nxt}); nxt = nxt + 32'h4;
            end else fetch_start = 1'b0;
         end
      end
      checks++; if (caps != 3) begin
         errors++; $display("FAIL b2b_count got=%0d exp=3", caps); end
      tick();
      checks++; if (pc !== 32'hC || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_final pc=%0h busy=%b exp c/0", pc, busy); end
   endtask

   task automatic test_redirect_idle();
      do_reset();
      pc_write = 1'b1; pc_src = 2'b00; tick(); tick(); pc_write = 1'b0;
      checks++; if (pc !== 32'h8) begin
         errors++; $display("FAIL idle_advance got=%0h exp=8", pc); end
      pc_write = 1'b1; pc_src = 2'b01; branch_target = 32'h40; fetch_start = 1'b1;
      exp_q.push_back('{imem[16], 32'h40});
      tick(); pc_write = 1'b0; fetch_start = 1'b0;
      checks++; if (mem_sel !== 1'b0 || mem_addr !== 32'h40 || pc !== 32'h40) begin
         errors++; $display("FAIL idle_redirect sel=%b addr=%0h pc=%0h exp 0/40/40", mem_sel, mem_addr, pc); end
      n = 0; while (ir_valid !== 1'b1 && n < 8) begin tick(); n++; end
      checks++; if (ir_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL idle_redirect_timeout valid=%b exp=1", ir_valid);
      end else begin
         e = exp_q.pop_front();
         if (ir !== e.ir || old_pc !== e.pc || pc !== 32'h44) begin
            errors++; $display("FAIL idle_redirect_capture ir=%0h old_pc=%0h pc=%0h exp %0h/40/44", ir, old_pc, pc, e.ir); end
      end
   endtask

   task automatic test_redirect_busy();
      do_reset();
      pc_write = 1'b1; pc_src = 2'b00; tick(); pc_write = 1'b0;
      fetch_start = 1'b1; exp_q.push_back('{imem[1], 32'h4});
      tick();
      // REQ: repeated fetch_start must be dropped; jump becomes pending.
      pc_write = 1'b1; pc_src = 2'b10; jump_target = 32'h20;
      tick();
      // WAIT: pc_src=11 must not disturb the pending jump.
      fetch_start = 1'b0; pc_src = 2'b11;
      checks++; if (pc !== 32'h4 || busy !== 1'b1) begin
         errors++; $display("FAIL busy_hold pc=%0h busy=%b exp 4/1", pc, busy); end
      tick(); pc_write = 1'b0; pc_src = 2'b00;
      checks++; if (ir_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL busy_valid got=%b exp=1", ir_valid);
      end else begin
         e = exp_q.pop_front();
         if (ir !== e.ir || old_pc !== e.pc || pc !== 32'h20 || pc_plus4 !== 32'h24) begin
            errors++; $display("FAIL busy_capture ir=%0h old_pc=%0h pc=%0h p4=%0h exp %0h/4/20/24", ir, old_pc, pc, pc_plus4, e.ir); end
      end
      tick();
      checks++; if (busy !== 1'b0 || mem_sel !== 1'b1 || pc !== 32'h20) begin
         errors++; $display("FAIL busy_not_queued busy=%b sel=%b pc=%0h exp 0/1/20", busy, mem_sel, pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      pc_write = 1'b1; pc_src = 2'b10; jump_target = 32'hFFFF_FFFC; tick(); pc_write = 1'b0;
      checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
         errors++; $display("FAIL wrap_plus4 pc=%0h p4=%0h exp fffffffc/0", pc, pc_plus4); end
`ifndef FETCH_ADDR_CHECK_EN
      fetch_start = 1'b1; exp_q.push_back('{imem[31], 32'hFFFF_FFFC});
      tick(); fetch_start = 1'b0;
      n = 0; while (ir_valid !== 1'b1 && n < 8) begin tick(); n++; end
      checks++; if (ir_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL wrap_timeout valid=%b exp=1", ir_valid);
      end else begin
         e = exp_q.pop_front();
         if (ir !== e.ir || old_pc !== e.pc || pc !== 32'h0) begin
            errors++; $display("FAIL wrap_capture ir=%0h old_pc=%0h pc=%0h exp %0h/fffffffc/0", ir, old_pc, pc, e.ir); end
      end
`endif
   endtask

   task automatic test_reset_midfetch();
      do_reset();
      fetch_start = 1'b1; exp_q.push_back('{imem[0], 32'h0});
      tick(); fetch_start = 1'b0;
      n = 0; while (ir_valid !== 1'b1 && n < 8) begin tick(); n++; end
      checks++; if (ir_valid !== 1'b1 || ir !== exp_q[0].ir) begin
         errors++; $display("FAIL mid_prefetch valid=%b ir=%0h exp 1/%0h", ir_valid, ir, exp_q[0].ir); end
      exp_q.delete();
      fetch_start = 1'b1; tick(); fetch_start = 1'b0; tick();
      reset = 1'b1; #1;
      checks++; if (pc !== 32'h0 || ir !== 32'h13 || mem_sel !== 1'b1 || busy !== 1'b0 || ir_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset pc=%0h ir=%0h sel=%b busy=%b valid=%b exp 0/13/1/0/0", pc, ir, mem_sel, busy, ir_valid); end
      tick(); reset = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (ir_valid !== 1'b0) n++; end
      checks++; if (n != 0) begin
         errors++; $display("FAIL mid_no_pulse got=%0d pulses exp=0", n); end
      fetch_start = 1'b1; exp_q.push_back('{imem[0], 32'h0});
      tick(); fetch_start = 1'b0;
      n = 0; while (ir_valid !== 1'b1 && n < 8) begin tick(); n++; end
      checks++; if (ir_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL mid_refetch_timeout valid=%b exp=1", ir_valid);
      end else begin
         e = exp_q.pop_front();
         if (ir !== e.ir || old_pc !== e.pc || pc !== 32'h4) begin
            errors++; $display("FAIL mid_refetch ir=%0h old_pc=%0h pc=%0h exp %0h/0/4", ir, old_pc, pc, e.ir); end
      end
   endtask

`ifdef FETCH_ADDR_CHECK_EN
   task automatic test_addr_check();
      logic [31:0] bad [2];
      bad[0] = 32'h6; bad[1] = 32'h80;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         pc_write = 1'b1; pc_src = 2'b10; jump_target = bad[k]; tick(); pc_write = 1'b0;
         fetch_start = 1'b1; exp_q.push_back('{32'h13, bad[k]});
         tick(); fetch_start = 1'b0;
         e = exp_q.pop_front();
         checks++; if (mem_sel !== 1'b1 || ir_valid !== 1'b1 || addr_err !== 1'b1 || ir !== e.ir || old_pc !== e.pc || pc !== bad[k]) begin
            errors++; $display("FAIL fault_%0h sel=%b v=%b err=%b ir=%0h old_pc=%0h pc=%0h exp 1/1/1/13/%0h/%0h",
                               bad[k], mem_sel, ir_valid, addr_err, ir, old_pc, pc, e.pc, bad[k]); end
         tick();
         checks++; if (ir_valid !== 1'b0 || addr_err !== 1'b0 || mem_sel !== 1'b1) begin
            errors++; $display("FAIL fault_pulse_%0h v=%b err=%b sel=%b exp 0/0/1", bad[k], ir_valid, addr_err, mem_sel); end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0013 | (32'(i + 1) << 20) | (32'(i) << 7);
      imem[0] = 32'h0050_0093;
      mem_instr = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_redirect_idle();
      test_redirect_busy();
      test_wrap();
      test_reset_midfetch();
`ifdef FETCH_ADDR_CHECK_EN
      test_addr_check();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
